// File: rtl/hc165_reader.sv
// hc165_reader: loads, clocks and samples a 74HC165 chain MSB-first and presents the word.
// Optional HC165_AUTOSCAN_EN: rescan continuously and ignore the start port.
module hc165_reader #(
  parameter int WIDTH  = 16,
  parameter int CLKDIV = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in165,
  output logic             ld165,
  output logic             clk165,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy
);

  localparam int PW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLKDIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] srShifted;
  logic             sync1_q, sync2_q;
  logic             ld165_q, clk165_q, busy_q, valid_q;
  logic [WIDTH-1:0] data_q;
  logic             scanReq;
  logic             phaseLast;

`ifdef HC165_AUTOSCAN_EN
  logic unusedStart;
  assign unusedStart = start;
  assign scanReq     = 1'b1;
`else
  assign scanReq = start;
`endif

  assign phaseLast = (phase_q == PHASE_LAST);

  // A one-bit chain has nothing to shift along, the sample simply replaces the register.
  generate
    if (WIDTH == 1) begin : g_single
      assign srShifted = sync2_q;
    end else begin : g_chain
      assign srShifted = {sr_q[WIDTH-2:0], sync2_q};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= in165;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (scanReq) begin
          state_d = LOAD;
          bit_d   = '0;
          sr_d    = '0;
        end
      end
      LOAD: begin
        if (phaseLast) begin
          phase_d = '0;
          state_d = SETTLE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      SETTLE: begin
        if (phaseLast) begin
          phase_d = '0;
          state_d = SHIFT_LO;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      SHIFT_LO: begin
        if (phaseLast) begin
          phase_d = '0;
          sr_d    = srShifted;
          state_d = SHIFT_HI;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (phaseLast) begin
          phase_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = DONE;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = SHIFT_LO;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered images of the current state, so every one lags the state by a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld165_q  <= 1'b1;
      clk165_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      ld165_q  <= (state_q != LOAD);
      clk165_q <= (state_q == SHIFT_HI);
      busy_q   <= (state_q != IDLE);
      valid_q  <= (state_q == DONE);
      if (state_q == DONE) begin
        data_q <= sr_q;
      end
    end
  end

  assign ld165    = ld165_q;
  assign clk165   = clk165_q;
  assign busy     = busy_q;
  assign valid    = valid_q;
  assign data_out = data_q;

endmodule

// File: doc/hc165_reader.md
# hc165_reader

Serial-input reader for a chain of 74HC165 parallel-in/serial-out shift registers; the input-side counterpart of the 74HC595 display driver. The block pulses the chain's parallel-load line, clocks the chain at a divided rate, samples the serial output MSB-first, and presents the captured word with a one-cycle valid strobe. It sits between the board's key/switch inputs and the user logic.

## Interface
- WIDTH, 16: number of bits in the chain (8 per chip); legal range 1..64.
- CLKDIV, 25: duration of every ld165/clk165 phase, in clk cycles; must be ≥3.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- start  input  1  one-cycle scan request; sampled only in IDLE.
- in165  input  1  serial data from the last chip's QH pin; asynchronous to clk.
- ld165  output  1  chain SH/LD; 0 = parallel load, idles at 1.
- clk165  output  1  chain shift clock; idles at 0.
- data_out  output  WIDTH  last captured word; bit WIDTH-1 is the first bit shifted out.
- valid  output  1  one-cycle pulse when data_out updates.
- busy  output  1  high while a scan is in progress.

## Operation
- in165 passes through a 2-flop synchronizer before use (2-cycle sampling latency, covered by CLKDIV ≥3).
- Phase counter counts 0..CLKDIV-1; bit counter counts 0..WIDTH-1 ($clog2 widths, no overflow).
- States: IDLE, LOAD, SETTLE, SHIFT_LO, SHIFT_HI, DONE.
- IDLE: ld165=1, clk165=0, busy=0. start=1 -> LOAD; bit counter and shift register cleared.
- LOAD: ld165=0 for CLKDIV cycles -> SETTLE.
- SETTLE: ld165=1, clk165=0 for CLKDIV cycles -> SHIFT_LO.
- SHIFT_LO: clk165=0 for CLKDIV cycles. On the last cycle, shift register <= {sr[WIDTH-2:0], synchronized in165} -> SHIFT_HI.
- SHIFT_HI: clk165=1 for CLKDIV cycles. On the last cycle, if bit counter = WIDTH-1 -> DONE, else increment the counter and go to SHIFT_LO.
- DONE: one cycle. data_out <= shift register, valid=1, busy=1 -> IDLE.
- start outside IDLE is ignored and is not queued.
- data_out holds its value between scans. It changes only in DONE.
- The WIDTH rising edges of clk165 leave the chain fully shifted. Only WIDTH samples are taken.

## Timing
- Reset values: ld165=1, clk165=0, data_out=0, valid=0, busy=0, state=IDLE, synchronizer flops=0.
- Reset asserted mid-scan aborts immediately to the reset values. No valid pulse is produced. The next scan begins only on a new start.
- start seen in IDLE at edge N:
  - busy=1 and ld165=0 from cycle N+1.
  - ld165 returns to 1 at N+1+CLKDIV.
  - First clk165 rise at N+1+3·CLKDIV.
  - valid at cycle N+1+(2+2·WIDTH)·CLKDIV.
  - busy=0 on the following cycle. start is accepted again on that cycle.
- Back-to-back: start held high continuously produces a scan every (2+2·WIDTH)·CLKDIV+2 cycles.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- HC165_AUTOSCAN_EN defined: the block scans continuously. IDLE lasts exactly one cycle, then LOAD follows regardless of start, and the start port is ignored. The first scan after reset deasserts begins on the first clk edge.
- HC165_AUTOSCAN_EN undefined: scans run only on start, as described above.

## Test plan
- Reset: hold rst for 5 cycles mid-scan -> ld165=1, clk165=0, busy=0, valid=0, data_out=0 on the cycle rst rises, with no clock edge required. No valid pulse after release.
- Single scan, WIDTH=16, CLKDIV=4, chain model preloaded with 16'hA5C3 -> exactly 16 clk165 rises, and valid at N+137 with data_out=16'hA5C3.
- Phase timing, WIDTH=8, CLKDIV=3 -> ld165 low for exactly 3 cycles. Every clk165 high/low phase lasts 3 cycles. data_out=8'h81 for pattern 8'h81.
- start pulsed during a scan (at N+50) -> ignored. Only one valid pulse, and busy stays continuously high until the valid cycle.
- Pattern change between scans: 16'hFFFF then 16'h0001 with start held high -> two valids 138 cycles apart, carrying FFFF then 0001, with data_out stable between them.
- HC165_AUTOSCAN_EN build, start tied 0 -> valid repeats every 138 cycles, with the first valid at cycle 137 after reset release.
